// File: rtl/collision_scanner.sv
// collision_scanner: checks a freshly moved head against the arena walls and
// the captured tail segments, one segment per cycle, and keeps the sticky
// end-of-game flags.
module collision_scanner #(
    parameter  int X_W       = 7,
    parameter  int Y_W       = 6,
    parameter  int MAX_TAIL  = 15,
    parameter  int SCORE_W   = 4,
    parameter  int WIN_SCORE = 15,
    parameter  int WRAP_MODE = 0,
    localparam int IDX_W     = (MAX_TAIL > 1) ? $clog2(MAX_TAIL) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [X_W-1:0]          head_x,
    input  logic [Y_W-1:0]          head_y,
    input  logic [MAX_TAIL*X_W-1:0] tail_x,
    input  logic [MAX_TAIL*Y_W-1:0] tail_y,
    input  logic [SCORE_W-1:0]      score,
    input  logic [X_W-1:0]          x_min,
    input  logic [X_W-1:0]          x_max,
    input  logic [Y_W-1:0]          y_min,
    input  logic [Y_W-1:0]          y_max,
    output logic                    busy,
    output logic                    done,
    output logic                    game_over,
    output logic                    victory,
    output logic [1:0]              hit_cause,
    output logic [IDX_W-1:0]        hit_index
);

    localparam int CNT_W = $clog2(MAX_TAIL + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FRAME  = 2'b01,
        SCAN   = 2'b10,
        RESULT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_WALL = 2'b01,
        CAUSE_BODY = 2'b10
    } cause_t;

    state_t state;
    state_t state_next;

    // Snapshot of the inputs taken when a check is accepted.
    logic [X_W-1:0]          cap_head_x;
    logic [Y_W-1:0]          cap_head_y;
    logic [MAX_TAIL*X_W-1:0] cap_tail_x;
    logic [MAX_TAIL*Y_W-1:0] cap_tail_y;
    logic [SCORE_W-1:0]      cap_score;
    logic [CNT_W-1:0]        cap_n;
    logic [X_W-1:0]          cap_x_min;
    logic [X_W-1:0]          cap_x_max;
    logic [Y_W-1:0]          cap_y_min;
    logic [Y_W-1:0]          cap_y_max;

    logic [IDX_W-1:0]        idx;

    // Result decided in FRAME/SCAN, published on the edge that leaves RESULT.
    cause_t                  pend_cause;
    logic [IDX_W-1:0]        pend_index;
    logic                    pend_win;

    // Control decoded by the next-state logic.
    logic                    capture;
    logic                    idx_clr;
    logic                    idx_inc;
    logic                    pend_load;
    cause_t                  pend_cause_next;
    logic                    pend_win_next;
    logic                    commit;

    logic [CNT_W-1:0]        n_in;
    logic [X_W-1:0]          seg_x;
    logic [Y_W-1:0]          seg_y;
    logic                    seg_match;
    logic                    win;
    logic                    wall;
    logic                    last_seg;

    assign busy = (state != IDLE);

    // Valid segment count from the live score: n = min(score, MAX_TAIL).
    always_comb begin
        if (32'(score) >= 32'(MAX_TAIL)) begin
            n_in = CNT_W'(MAX_TAIL);
        end else begin
            n_in = CNT_W'(score);
        end
    end

    // Select the captured segment addressed by idx.
    always_comb begin
        seg_x = '0;
        seg_y = '0;
        for (int unsigned i = 0; i < MAX_TAIL; i++) begin
            if (32'(idx) == i) begin
                seg_x = cap_tail_x[i*X_W +: X_W];
                seg_y = cap_tail_y[i*Y_W +: Y_W];
            end
        end
    end

    assign seg_match = (seg_x == cap_head_x) && (seg_y == cap_head_y);
    assign win       = (32'(cap_score) >= 32'(WIN_SCORE));
    assign wall      = (cap_head_x <= cap_x_min) || (cap_head_x >= cap_x_max) ||
                       (cap_head_y <= cap_y_min) || (cap_head_y >= cap_y_max);
    assign last_seg  = (32'(idx) == (32'(cap_n) - 32'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next      = state;
        capture         = 1'b0;
        idx_clr         = 1'b0;
        idx_inc         = 1'b0;
        pend_load       = 1'b0;
        pend_cause_next = CAUSE_NONE;
        pend_win_next   = 1'b0;
        commit          = 1'b0;
        case (state)
            IDLE: begin
                if (start && !game_over && !victory) begin
                    capture    = 1'b1;
                    state_next = FRAME;
                end
            end
            FRAME: begin
                if (win) begin
                    pend_load     = 1'b1;
                    pend_win_next = 1'b1;
                    state_next    = RESULT;
                end else if ((WRAP_MODE == 0) && wall) begin
                    pend_load       = 1'b1;
                    pend_cause_next = CAUSE_WALL;
                    state_next      = RESULT;
                end else if (cap_n == '0) begin
                    pend_load  = 1'b1;
                    state_next = RESULT;
                end else begin
                    idx_clr    = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (seg_match) begin
                    pend_load       = 1'b1;
                    pend_cause_next = CAUSE_BODY;
                    state_next      = RESULT;
                end else if (last_seg) begin
                    pend_load  = 1'b1;
                    state_next = RESULT;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            RESULT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture, scan index, pending result and published outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_head_x <= '0;
            cap_head_y <= '0;
            cap_tail_x <= '0;
            cap_tail_y <= '0;
            cap_score  <= '0;
            cap_n      <= '0;
            cap_x_min  <= '0;
            cap_x_max  <= '0;
            cap_y_min  <= '0;
            cap_y_max  <= '0;
            idx        <= '0;
            pend_cause <= CAUSE_NONE;
            pend_index <= '0;
            pend_win   <= 1'b0;
            done       <= 1'b0;
            game_over  <= 1'b0;
            victory    <= 1'b0;
            hit_cause  <= '0;
            hit_index  <= '0;
        end else begin
            done <= commit;
            if (capture) begin
                cap_head_x <= head_x;
                cap_head_y <= head_y;
                cap_tail_x <= tail_x;
                cap_tail_y <= tail_y;
                cap_score  <= score;
                cap_n      <= n_in;
                cap_x_min  <= x_min;
                cap_x_max  <= x_max;
                cap_y_min  <= y_min;
                cap_y_max  <= y_max;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (pend_load) begin
                pend_cause <= pend_cause_next;
                pend_index <= idx;
                pend_win   <= pend_win_next;
            end
            if (commit) begin
                hit_cause <= pend_cause;
                hit_index <= (pend_cause == CAUSE_BODY) ? pend_index : '0;
                if (pend_win) begin
                    victory <= 1'b1;
                end
                if ((pend_cause == CAUSE_WALL) || (pend_cause == CAUSE_BODY)) begin
                    game_over <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: wall, body, no-hit, victory, wrap,
// stale segments, input stability during a scan and reset behaviour.
module tb_collision_scanner;

    localparam int X_W      = 7;
    localparam int Y_W      = 6;
    localparam int MAX_TAIL = 15;
    localparam int SCORE_W  = 4;
    localparam int IDX_W    = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    start2;
    logic [X_W-1:0]          head_x;
    logic [Y_W-1:0]          head_y;
    logic [MAX_TAIL*X_W-1:0] tail_x;
    logic [MAX_TAIL*Y_W-1:0] tail_y;
    logic [SCORE_W-1:0]      score;
    logic [X_W-1:0]          x_min;
    logic [X_W-1:0]          x_max;
    logic [Y_W-1:0]          y_min;
    logic [Y_W-1:0]          y_max;

    logic             busy, done, game_over, victory;
    logic [1:0]       hit_cause;
    logic [IDX_W-1:0] hit_index;
    logic             busy2, done2, game_over2, victory2;
    logic [1:0]       hit_cause2;
    logic [IDX_W-1:0] hit_index2;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int lat      = 0;
    int ndone    = 0;
    logic sel    = 1'b0;

    logic done_s;
    logic busy_s;
    assign done_s = sel ? done2 : done;
    assign busy_s = sel ? busy2 : busy;

    collision_scanner #(
        .X_W(X_W), .Y_W(Y_W), .MAX_TAIL(MAX_TAIL), .SCORE_W(SCORE_W),
        .WIN_SCORE(15), .WRAP_MODE(0)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .score(score), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .busy(busy), .done(done), .game_over(game_over), .victory(victory),
        .hit_cause(hit_cause), .hit_index(hit_index)
    );

    collision_scanner #(
        .X_W(X_W), .Y_W(Y_W), .MAX_TAIL(MAX_TAIL), .SCORE_W(SCORE_W),
        .WIN_SCORE(15), .WRAP_MODE(1)
    ) u_wrap (
        .clk(clk), .reset(reset), .start(start2),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .score(score), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .busy(busy2), .done(done2), .game_over(game_over2), .victory(victory2),
        .hit_cause(hit_cause2), .hit_index(hit_index2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_c();
        tick();
        cyc++;
    endtask

    task automatic set_seg(input int i, input int x, input int y);
        tail_x[i*X_W +: X_W] = X_W'(x);
        tail_y[i*Y_W +: Y_W] = Y_W'(y);
    endtask

    // Fill every slot with a position that never matches test heads.
    task automatic clear_segs();
        for (int i = 0; i < MAX_TAIL; i++) set_seg(i, 60 + i, 40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Pulse start for the selected instance; cyc counts edges after acceptance.
    task automatic launch();
        if (sel) start2 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
        cyc    = 0;
    endtask

    task automatic wait_done(input string tag);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            tick_c();
            if (done_s) begin
                lat = cyc;
                break;
            end
        end
        if (lat < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        head_x = '0; head_y = '0; tail_x = '0; tail_y = '0; score = '0;
        x_min = 7'd0; x_max = 7'd79; y_min = 6'd0; y_max = 6'd59;
        clear_segs();
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_go", 32'(game_over), 32'd0);
        chk("rst_vic", 32'(victory), 32'd0);
        chk("rst_cause", 32'(hit_cause), 32'd0);
        chk("rst_idx", 32'(hit_index), 32'd0);

        // Body hit at segment 3 with n=5
        score = 4'd5; head_x = 7'd20; head_y = 6'd20;
        set_seg(3, 20, 20);
        launch();
        chk("body3_busy", 32'(busy), 32'd1);
        wait_done("body3");
        chk("body3_lat", 32'(lat), 32'd6);
        chk("body3_cause", 32'(hit_cause), 32'd2);
        chk("body3_idx", 32'(hit_index), 32'd3);
        chk("body3_go", 32'(game_over), 32'd1);
        chk("body3_vic", 32'(victory), 32'd0);
        tick();
        chk("body3_pulse", 32'(done), 32'd0);
        chk("body3_hold", 32'(hit_cause), 32'd2);
        // Sticky: further starts ignored
        launch();
        chk("sticky_busy", 32'(busy), 32'd0);
        chk("sticky_go", 32'(game_over), 32'd1);
        do_reset();

        // Stale matches at and beyond n=5 (including segment 8) never compared
        clear_segs();
        for (int i = 5; i < MAX_TAIL; i++) set_seg(i, 20, 20);
        launch();
        wait_done("stale");
        chk("stale_lat", 32'(lat), 32'd7);
        chk("stale_cause", 32'(hit_cause), 32'd0);
        chk("stale_go", 32'(game_over), 32'd0);

        // Hit on the last valid segment n-1=4
        set_seg(4, 20, 20);
        launch();
        wait_done("last");
        chk("last_lat", 32'(lat), 32'd7);
        chk("last_cause", 32'(hit_cause), 32'd2);
        chk("last_idx", 32'(hit_index), 32'd4);
        do_reset();

        // Input changes and a second start while busy do not disturb the check
        clear_segs();
        score = 4'd5; head_x = 7'd20; head_y = 6'd20;
        launch();
        set_seg(0, 20, 20);
        score  = 4'd15;
        head_x = 7'd0;
        start  = 1'b1;
        tick_c();
        start = 1'b0;
        wait_done("stable");
        chk("stable_lat", 32'(lat), 32'd7);
        chk("stable_cause", 32'(hit_cause), 32'd0);
        chk("stable_go", 32'(game_over), 32'd0);
        chk("stable_vic", 32'(victory), 32'd0);
        tick(); tick();
        chk("stable_single", 32'(done), 32'd0);
        chk("stable_idle", 32'(busy), 32'd0);

        // n=14 full scan, segment 14 overlaps but is out of range
        clear_segs();
        set_seg(14, 40, 30);
        score = 4'd14; head_x = 7'd40; head_y = 6'd30;
        launch();
        wait_done("n14");
        chk("n14_lat", 32'(lat), 32'd16);
        chk("n14_cause", 32'(hit_cause), 32'd0);
        chk("n14_go", 32'(game_over), 32'd0);
        chk("n14_vic", 32'(victory), 32'd0);

        // Victory at score=15 even with an overlapping segment 0
        set_seg(0, 40, 30);
        score = 4'd15;
        launch();
        wait_done("win");
        chk("win_lat", 32'(lat), 32'd2);
        chk("win_vic", 32'(victory), 32'd1);
        chk("win_go", 32'(game_over), 32'd0);
        chk("win_cause", 32'(hit_cause), 32'd0);
        launch();
        chk("win_sticky_busy", 32'(busy), 32'd0);
        do_reset();
        chk("win_cleared", 32'(victory), 32'd0);

        // Walls: x at x_min, x at x_max, y at y_max; inside corner is clear
        clear_segs();
        score = 4'd0; head_x = 7'd0; head_y = 6'd10;
        launch();
        wait_done("wallx0");
        chk("wallx0_lat", 32'(lat), 32'd2);
        chk("wallx0_cause", 32'(hit_cause), 32'd1);
        chk("wallx0_go", 32'(game_over), 32'd1);
        do_reset();
        head_x = 7'd79; head_y = 6'd10;
        launch();
        wait_done("wallx79");
        chk("wallx79_cause", 32'(hit_cause), 32'd1);
        do_reset();
        head_x = 7'd78; head_y = 6'd58;
        launch();
        wait_done("inner");
        chk("inner_lat", 32'(lat), 32'd2);
        chk("inner_cause", 32'(hit_cause), 32'd0);
        chk("inner_go", 32'(game_over), 32'd0);
        head_x = 7'd10; head_y = 6'd59;
        launch();
        wait_done("wally59");
        chk("wally59_cause", 32'(hit_cause), 32'd1);
        do_reset();

        // Reset while scanning at idx=2, following a body result to clear
        clear_segs();
        set_seg(1, 20, 20);
        score = 4'd10; head_x = 7'd20; head_y = 6'd20;
        launch();
        wait_done("pre");
        chk("pre_cause", 32'(hit_cause), 32'd2);
        do_reset();
        clear_segs();
        set_seg(8, 20, 20);
        score = 4'd5;
        launch();
        tick_c(); tick_c(); tick_c();
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_go", 32'(game_over), 32'd0);
        chk("mid_cause", 32'(hit_cause), 32'd0);
        chk("mid_idx", 32'(hit_index), 32'd0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_no_done", 32'(ndone), 32'd0);

        // Reset has priority over a simultaneous start
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("prio_busy", 32'(busy), 32'd0);

        // Wrap instance: head on a wall, n=0, extra start while busy
        sel = 1'b1;
        score = 4'd0; head_x = 7'd0; head_y = 6'd0;
        launch();
        start2 = 1'b1;
        tick_c();
        start2 = 1'b0;
        wait_done("wrap");
        chk("wrap_lat", 32'(lat), 32'd2);
        chk("wrap_cause", 32'(hit_cause2), 32'd0);
        chk("wrap_go", 32'(game_over2), 32'd0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done2) ndone++;
        end
        chk("wrap_single", 32'(ndone), 32'd0);
        chk("wrap_idle", 32'(busy_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
